ex_muldiv_sequencer: RTL and testbench

- Iterative multi-cycle sequencer for RV32M multiply/divide, sitting beside the EX-stage ALU.
- Receives forwarded operands and the funct3 op from EX.
- Raises a stall request to the hazard unit while an operation runs, then presents a one-cycle result to EX/MEM packing.
- Shift-add multiply and restoring divide, one bit per cycle; one shared accumulator/counter datapath.

---
 rtl/ex_muldiv_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// ex_muldiv_sequencer
//
// Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
// It uses shift-add multiply and restoring divide, one bit per cycle, on one
// shared 2*XLEN accumulator and iteration counter. While an operation runs it
// raises a stall request. When the operation ends it shows the result for
// one cycle.
//
// Ports
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset
//   start          : EX holds a valid M-extension instruction
//   flush          : kill the in-flight or requested operation
//   op             : funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   rs1_data       : forwarded rs1 operand
//   rs2_data       : forwarded rs2 operand
//   rd_addr        : destination register
//   stall          : freeze IF/ID/EX, bubble into MEM
//   busy           : sequencer is iterating
//   result_valid   : result is valid this cycle (single-cycle pulse)
//   result         : final result, holds its value outside the valid cycle
//   result_rd_addr : rd captured at start, holds its value outside the valid cycle
// ---------------------------------------------------------------------------
module ex_muldiv_sequencer #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_W          = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      flush,
  input  logic [2:0]                op,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic                      stall,
  output logic                      busy,
  output logic                      result_valid,
  output logic [XLEN-1:0]           result,
  output logic [REG_ADDR_WIDTH-1:0] result_rd_addr
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [2*XLEN-1:0]           r_acc;     // mul: {partial, multiplier}; div: {rem, quot}
  logic [XLEN-1:0]             r_opb;     // multiplicand or divisor magnitude
  logic [2:0]                  r_op;
  logic [REG_ADDR_WIDTH-1:0]   r_rd;
  logic                        r_neg_lo;  // negate product / quotient
  logic                        r_neg_hi;  // negate remainder
  logic [XLEN-1:0]             r_result;
  logic [REG_ADDR_WIDTH-1:0]   r_rd_out;
  logic                        r_valid;
  logic                        r_busy;

  // Operand decode at issue
  logic                        w_signed_div;
  logic                        w_sa;
  logic                        w_sb;
  logic [XLEN-1:0]             w_a_mag;
  logic [XLEN-1:0]             w_b_mag;
  logic                        w_div_zero;
  logic                        w_div_ovf;
  logic                        w_fast;
  logic [XLEN-1:0]             w_fast_result;

  // Iteration datapath
  logic [XLEN:0]               w_sum;
  logic [2*XLEN-1:0]           w_mul_nxt;
  logic [XLEN:0]               w_rem_sh;
  logic                        w_ge;
  logic [XLEN-1:0]             w_sub;
  logic [2*XLEN-1:0]           w_div_nxt;
  logic [2*XLEN-1:0]           w_acc_nxt;
  logic [2*XLEN-1:0]           w_prod_s;
  logic [XLEN-1:0]             w_quot;
  logic [XLEN-1:0]             w_rem;
  logic [XLEN-1:0]             w_final;

  // DIV and REM are the signed divides (even funct3 with bit 2 set)
  assign w_signed_div = op[2] & ~op[0];
  assign w_sa = rs1_data[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) | w_signed_div);
  assign w_sb = rs2_data[XLEN-1] & ((op == OP_MULH) | w_signed_div);
  assign w_a_mag = w_sa ? (~rs1_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_data;
  assign w_b_mag = w_sb ? (~rs2_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_data;

  assign w_div_zero = op[2] & (rs2_data == {XLEN{1'b0}});
  assign w_div_ovf  = w_signed_div & (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                      & (rs2_data == {XLEN{1'b1}});
  assign w_fast     = w_div_zero | w_div_ovf;

  // Result of the fast path; op[1] marks the remainder ops
  always_comb begin
    w_fast_result = {XLEN{1'b0}};
    if (w_div_zero) begin
      w_fast_result = op[1] ? rs1_data : {XLEN{1'b1}};
    end else begin
      w_fast_result = op[1] ? {XLEN{1'b0}} : rs1_data;
    end
  end

  // Multiply step: add the multiplicand to the upper half when the multiplier LSB is set, then shift right
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
  assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

  // Divide step: the shifted remainder needs XLEN+1 bits. The committed
  // difference is always below the divisor, so it fits in XLEN bits.
  assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_opb});
  assign w_sub     = w_rem_sh[XLEN-1:0] - r_opb;
  assign w_div_nxt = w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1}
                          : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

  // Sign fix-up on the final accumulator value
  assign w_prod_s = r_neg_lo ? (~w_acc_nxt + {{(2*XLEN-1){1'b0}}, 1'b1}) : w_acc_nxt;
  assign w_quot   = r_neg_lo ? (~w_acc_nxt[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                             : w_acc_nxt[XLEN-1:0];
  assign w_rem    = r_neg_hi ? (~w_acc_nxt[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                             : w_acc_nxt[2*XLEN-1:XLEN];

  // Select the architectural result for the latched op
  always_comb begin
    w_final = {XLEN{1'b0}};
    case (r_op)
      OP_MUL:    w_final = w_prod_s[XLEN-1:0];
      OP_MULH:   w_final = w_prod_s[2*XLEN-1:XLEN];
      OP_MULHSU: w_final = w_prod_s[2*XLEN-1:XLEN];
      OP_MULHU:  w_final = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV:    w_final = w_quot;
      OP_DIVU:   w_final = w_quot;
      OP_REM:    w_final = w_rem;
      OP_REMU:   w_final = w_rem;
      default:   w_final = {XLEN{1'b0}};
    endcase
  end

  // Sequencer FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {(2*XLEN){1'b0}};
      r_opb    <= {XLEN{1'b0}};
      r_op     <= 3'd0;
      r_rd     <= {REG_ADDR_WIDTH{1'b0}};
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_result <= {XLEN{1'b0}};
      r_rd_out <= {REG_ADDR_WIDTH{1'b0}};
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_rd     <= rd_addr;
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= w_sa;
            if (w_fast) begin
              r_result <= w_fast_result;
              r_rd_out <= rd_addr;
              r_valid  <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, w_a_mag};
              r_opb   <= w_b_mag;
              r_cnt   <= CNT_W'(XLEN-1);
              r_valid <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_BUSY;
            end
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_result <= w_final;
            r_rd_out <= r_rd;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_busy <= 1'b1;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The stall request is combinational so that EX freezes in the same cycle as the request.
  // It is gated by reset so that it goes low at once while reset is asserted.
  assign stall = reset & ~flush & (((r_state == S_IDLE) & start) | (r_state == S_BUSY));

  assign busy           = r_busy;
  assign result_valid   = r_valid & ~flush;
  assign result         = r_result;
  assign result_rd_addr = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ex_muldiv_sequencer: directed cases, flush/reset
// scenarios, and random ops compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd_addr;

  int n_checks;
  int n_fail;

  ex_muldiv_sequencer #(.XLEN(32), .REG_ADDR_WIDTH(5), .CNT_W(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .flush          (flush),
    .op             (op),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .rd_addr        (rd_addr),
    .stall          (stall),
    .busy           (busy),
    .result_valid   (result_valid),
    .result         (result),
    .result_rd_addr (result_rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // RV32M results computed with plain 64-bit and signed arithmetic
  function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu;
    logic        [63:0] p;
    logic signed [31:0] qa, qb, qr;
    logic               ovf;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    sbu = $signed({32'd0, b});
    qa  = $signed(a);
    qb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * sbu;                return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        qr = qa / qb; return qr;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        qr = qa % qb; return qr;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one op and follow it to its result cycle. Optionally flush in the DONE cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit kill_done);
    int cyc, n_stall, n_busy;
    bit got, fast;
    logic [31:0] exp;
    fast = f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp  = ref_calc(f, a, b);
    @(negedge clk);
    flush = 1'b0; start = 1'b1; op = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    #1;
    chk("stall_issue", 32'(stall), 32'd1);
    chk("busy_issue", 32'(busy), 32'd0);
    chk("valid_issue", 32'(result_valid), 32'd0);
    n_stall = 1; n_busy = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      if (result_valid) got = 1'b1;
      else begin
        if (stall) n_stall++;
        if (busy)  n_busy++;
      end
    end
    chk("latency", cyc, fast ? 32'd1 : 32'd33);
    chk("stall_cycles", n_stall, fast ? 32'd1 : 32'd33);
    chk("busy_cycles", n_busy, fast ? 32'd0 : 32'd32);
    chk("result", result, exp);
    chk("result_rd", 32'(result_rd_addr), 32'(rd));
    chk("stall_done", 32'(stall), 32'd0);
    if (kill_done) begin
      flush = 1'b1;
      #1;
      chk("flush_done_valid", 32'(result_valid), 32'd0);
      chk("flush_done_stall", 32'(stall), 32'd0);
    end
    start = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      #1;
      chk("idle_valid", 32'(result_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
    end
  endtask

  logic [2:0]  d_op  [14];
  logic [31:0] d_a   [14];
  logic [31:0] d_b   [14];

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          sel;
    n_checks = 0; n_fail = 0;
    reset = 1'b0; start = 1'b1; flush = 1'b0; op = 3'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; rd_addr = 5'd0;

    // Reset state, including stall held low while start is high
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(result_rd_addr), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_check(2);

    // Directed cases
    d_op[0]  = 3'd0; d_a[0]  = 32'd7;          d_b[0]  = 32'hFFFF_FFFD;
    d_op[1]  = 3'd3; d_a[1]  = 32'hFFFF_FFFF;  d_b[1]  = 32'hFFFF_FFFF;
    d_op[2]  = 3'd1; d_a[2]  = 32'hFFFF_FFFF;  d_b[2]  = 32'hFFFF_FFFF;
    d_op[3]  = 3'd2; d_a[3]  = 32'hFFFF_FFFF;  d_b[3]  = 32'd2;
    d_op[4]  = 3'd4; d_a[4]  = 32'hFFFF_FFF9;  d_b[4]  = 32'd2;
    d_op[5]  = 3'd6; d_a[5]  = 32'hFFFF_FFF9;  d_b[5]  = 32'd2;
    d_op[6]  = 3'd5; d_a[6]  = 32'd100;        d_b[6]  = 32'd7;
    d_op[7]  = 3'd7; d_a[7]  = 32'd100;        d_b[7]  = 32'd7;
    d_op[8]  = 3'd5; d_a[8]  = 32'h1234;       d_b[8]  = 32'd0;
    d_op[9]  = 3'd7; d_a[9]  = 32'h1234;       d_b[9]  = 32'd0;
    d_op[10] = 3'd4; d_a[10] = 32'h8000_0000;  d_b[10] = 32'hFFFF_FFFF;
    d_op[11] = 3'd6; d_a[11] = 32'h8000_0000;  d_b[11] = 32'hFFFF_FFFF;
    d_op[12] = 3'd4; d_a[12] = 32'h8000_0000;  d_b[12] = 32'd3;
    d_op[13] = 3'd6; d_a[13] = 32'd17;         d_b[13] = 32'hFFFF_FFFB;
    for (int i = 0; i < 14; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], 5'(i + 3), 1'b0);
      idle_check(1);
    end

    // Flush in BUSY cycle 10, then a MUL 3*5
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr = 5'd9;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_busy_stall", 32'(stall), 32'd0);
    chk("flush_busy_busy", 32'(busy), 32'd1);
    chk("flush_busy_valid", 32'(result_valid), 32'd0);
    idle_check(1);
    run_op(3'd0, 32'd3, 32'd5, 5'd12, 1'b0);
    idle_check(1);

    // Flush together with start in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1_data = 32'd4; rs2_data = 32'd4; rd_addr = 5'd1;
    #1;
    chk("flush_idle_stall", 32'(stall), 32'd0);
    idle_check(3);

    // Flush during DONE suppresses the result pulse
    run_op(3'd5, 32'd50, 32'd5, 5'd20, 1'b1);
    idle_check(2);

    // Reset in BUSY cycle 5
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr = 5'd3;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd", 32'(result_rd_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    idle_check(2);

    // Back-to-back MULs
    run_op(3'd0, 32'd2, 32'd3, 5'd5, 1'b0);
    run_op(3'd0, 32'd4, 32'd5, 5'd6, 1'b0);
    idle_check(3);

    // Random ops, some of them back-to-back
    for (int i = 0; i < 40; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = rb >> $urandom_range(1, 31);
      run_op(rf, ra, rb, 5'($urandom_range(0, 31)), 1'b0);
      if ($urandom_range(0, 1) == 0) idle_check(1);
    end
    idle_check(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
